cordic_vectoring: RTL

Inverse of the rotation-mode sine/cosine engine. Takes a Cartesian vector (x, y) and iteratively rotates it onto the +x axis, producing its angle (atan2) and gain-compensated magnitude. It is a multi-cycle FSM with the same valid_in / done level handshake as the rest of the pipeline. It sits between the input converter and result_converter.

---
 rtl/cordic_pkg.sv | 27 ++
 rtl/cordic_vectoring_if.sv | 23 ++
 rtl/cordic_atan_lut.sv | 10 +
 rtl/cordic_vectoring.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, gain compensation, angle scale and FSM encoding.
// Imported by both the vectoring and rotation engines.
package cordic_pkg;

    localparam int          ATAN_N  = 16;
    localparam logic [15:0] K_INV   = 16'h4DBA;
    localparam logic [15:0] ANG_45  = 16'h4000;
    localparam logic [15:0] ANG_MAX = 16'h7FFF;

    // atan(2^-i) in units where 0x4000 = 45 degrees
    localparam logic [15:0] ATAN_TABLE [0:ATAN_N-1] = '{
        16'h4000, 16'h25C8, 16'h13F6, 16'h0A22,
        16'h0516, 16'h028B, 16'h0145, 16'h00A2,
        16'h0051, 16'h0029, 16'h0014, 16'h000A,
        16'h0005, 16'h0003, 16'h0002, 16'h0001
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_CHECK,
        ST_ROTATE,
        ST_SCALE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/cordic_vectoring_if.sv
// Request/result bundle between the input converter, the vectoring engine and result_converter.
// valid_in is a level held until done is seen; outputs are valid while done is high.
interface cordic_vectoring_if #(
    parameter int WIDTH = 16
);
    logic                    valid_in;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic        [WIDTH-1:0] angle_out;
    logic        [WIDTH-1:0] mag_out;
    logic                    err;
    logic                    done;

    modport master (
        output valid_in, x_in, y_in,
        input  angle_out, mag_out, err, done
    );

    modport slave (
        input  valid_in, x_in, y_in,
        output angle_out, mag_out, err, done
    );
endinterface

// File: rtl/cordic_atan_lut.sv
// Combinational index-to-arctangent lookup shared by the CORDIC engines.
// Zero latency; no flow control.
module cordic_atan_lut
    import cordic_pkg::*;
(
    input  logic [3:0]  idx,
    output logic [15:0] atan
);
    assign atan = ATAN_TABLE[idx];
endmodule

// File: rtl/cordic_vectoring.sv
// Vectoring-mode CORDIC: atan2(y, x) and gain-compensated magnitude for x >= 0, level valid_in/done handshake.
// Latency 37 edges iterative (36 without CORDIC_MAG_EN, mag_out then tied 0), 2 edges on shortcuts; holds DONE while valid_in stays high.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GUARD = 2
) (
    input  logic            clk,
    input  logic            rst,
    cordic_vectoring_if.slave bus
);
    localparam int XW = WIDTH + GUARD;
    localparam int ZW = WIDTH + 1;
    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [IW-1:0]        ITER = IW'(WIDTH);
    localparam logic signed [ZW-1:0] ZMAX = ZW'(2**(WIDTH-1) - 1);
    localparam logic signed [ZW-1:0] ZMIN = ZW'(-(2**(WIDTH-1)));

    state_t                  state;
    logic signed [WIDTH-1:0] x_lat, y_lat;
    logic signed [XW-1:0]    x, y;
    logic signed [ZW-1:0]    z;
    logic [IW-1:0]           i;
    logic [WIDTH-1:0]        angle_r;
    logic                    err_r, done_r;

    logic [15:0]             atan_val;
    logic signed [ZW-1:0]    atan_ext;
    logic signed [XW-1:0]    x_sh, y_sh;
    logic [WIDTH-1:0]        angle_sat;

    cordic_atan_lut u_lut (
        .idx  (i[3:0]),
        .atan (atan_val)
    );

    assign atan_ext = $signed({{(ZW-16){1'b0}}, atan_val});
    assign x_sh     = x >>> i;
    assign y_sh     = y >>> i;

    always_comb begin
        angle_sat = z[WIDTH-1:0];
        if (z > ZMAX)
            angle_sat = ZMAX[WIDTH-1:0];
        else if (z < ZMIN)
            angle_sat = ZMIN[WIDTH-1:0];
    end

`ifdef CORDIC_MAG_EN
    localparam logic signed [XW+16:0] PMAX = (XW+17)'(2**(WIDTH-1) - 1);

    logic signed [XW+16:0] prod, prod_sh;
    logic [WIDTH-1:0]      mag_sat, mag_r;

    assign prod    = x * $signed({1'b0, K_INV});
    assign prod_sh = prod >>> 15;

    always_comb begin
        mag_sat = prod_sh[WIDTH-1:0];
        if (prod_sh < 0)
            mag_sat = '0;
        else if (prod_sh > PMAX)
            mag_sat = PMAX[WIDTH-1:0];
    end

    assign bus.mag_out = mag_r;
`else
    assign bus.mag_out = '0;
`endif

    assign bus.angle_out = angle_r;
    assign bus.err       = err_r;
    assign bus.done      = done_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            x_lat   <= '0;
            y_lat   <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            i       <= '0;
            angle_r <= '0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
`ifdef CORDIC_MAG_EN
            mag_r   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.valid_in) begin
                        x_lat <= bus.x_in;
                        y_lat <= bus.y_in;
                        if (bus.x_in[WIDTH-1]) begin
                            err_r   <= 1'b1;
                            angle_r <= '0;
`ifdef CORDIC_MAG_EN
                            mag_r   <= '0;
`endif
                            state   <= ST_DONE;
                        end else if (bus.y_in == '0) begin
                            // Covers both the origin and the +x axis: magnitude is x itself
                            err_r   <= 1'b0;
                            angle_r <= '0;
`ifdef CORDIC_MAG_EN
                            mag_r   <= bus.x_in;
`endif
                            state   <= ST_DONE;
                        end else begin
                            err_r <= 1'b0;
                            state <= ST_INIT;
                        end
                    end
                end
                ST_INIT: begin
                    x     <= XW'(x_lat);
                    y     <= XW'(y_lat);
                    z     <= '0;
                    i     <= '0;
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (i < ITER) begin
                        state <= ST_ROTATE;
                    end else begin
`ifdef CORDIC_MAG_EN
                        state   <= ST_SCALE;
`else
                        angle_r <= angle_sat;
                        state   <= ST_DONE;
`endif
                    end
                end
                ST_ROTATE: begin
                    // Drive the residual y toward zero; z accumulates the angle rotated through
                    if (!y[XW-1]) begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + atan_ext;
                    end else begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - atan_ext;
                    end
                    i     <= i + 1'b1;
                    state <= ST_CHECK;
                end
                ST_SCALE: begin
                    angle_r <= angle_sat;
`ifdef CORDIC_MAG_EN
                    mag_r   <= mag_sat;
`endif
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    done_r <= 1'b1;
                    if (!bus.valid_in)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
